// File: rtl/in_port_fifo_if.sv
// -----------------------------------------------------------------------------
// in_port_fifo_if
// Purpose : Groups the handshake, CPU strobe, data and status signals of the
//           input-port FIFO so they can be passed as one interface port.
// Signals : ext_data/ext_valid/ext_ready - external device push handshake
//           InPort_out/InPort_Data       - CPU bus-drive strobe and read data
//           empty/full/count             - occupancy status
//           overflow/underflow/flag_clr  - sticky error flags and their clear
// Modports: master - external device / CPU side (drives pushes and strobes)
//           slave  - the FIFO itself
// -----------------------------------------------------------------------------
interface in_port_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 2
);
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_valid;
    logic                  ext_ready;
    logic                  InPort_out;
    logic [DATA_WIDTH-1:0] InPort_Data;
    logic                  empty;
    logic                  full;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;
    logic                  flag_clr;

    modport master (
        output ext_data, ext_valid, InPort_out, flag_clr,
        input  ext_ready, InPort_Data, empty, full, count, overflow, underflow
    );

    modport slave (
        input  ext_data, ext_valid, InPort_out, flag_clr,
        output ext_ready, InPort_Data, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/in_port_fifo.sv
// -----------------------------------------------------------------------------
// in_port_fifo
// Purpose : Input-port FIFO. An external device pushes words with a
//           valid/ready handshake; the CPU consumes one word per InPort_out
//           assertion, on the falling edge of that strobe, so the word on
//           InPort_Data stays stable for the whole assertion window.
// Ports   : clk  - system clock, all state updates on the rising edge
//           clr  - synchronous active-high reset
//           bus  - in_port_fifo_if.slave (handshake, strobe, data, status)
// -----------------------------------------------------------------------------
module in_port_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic           clk,
    input  logic           clr,
    in_port_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q,      wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q,      rd_ptr_d;
    logic [ADDR_W:0]       count_q,       count_d;
    logic [DATA_WIDTH-1:0] hold_q,        hold_d;
    logic                  strobe_prev_q;
    logic                  overflow_q,    overflow_d;
    logic                  underflow_q,   underflow_d;

    logic                  empty_s;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_evt_s;
    logic                  pop_s;

    // Occupancy comes from the separate counter, so full/empty never alias
    // when the pointers are equal.
    assign empty_s = (count_q == {(ADDR_W + 1){1'b0}});
    assign full_s  = (count_q == FULL_CNT);

    // Next-state logic for pointers, count, hold register and sticky flags.
    always_comb begin
        push_s      = bus.ext_valid & ~full_s;
        // A read completes when the strobe drops, not when it rises.
        pop_evt_s   = strobe_prev_q & ~bus.InPort_out;
        pop_s       = pop_evt_s & ~empty_s;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        hold_d      = hold_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            hold_d   = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            hold_d   = hold_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // Set conditions take priority over the flag clear.
        if (bus.ext_valid && full_s) begin
            overflow_d = 1'b1;
        end else if (bus.flag_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (pop_evt_s && empty_s) begin
            underflow_d = 1'b1;
        end else if (bus.flag_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q      <= {ADDR_W{1'b0}};
            rd_ptr_q      <= {ADDR_W{1'b0}};
            count_q       <= {(ADDR_W + 1){1'b0}};
            hold_q        <= {DATA_WIDTH{1'b0}};
            strobe_prev_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            hold_q        <= hold_d;
            strobe_prev_q <= bus.InPort_out;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!clr && push_s) begin
            mem_q[wr_ptr_q] <= bus.ext_data;
        end
    end

    assign bus.ext_ready   = ~full_s;
    assign bus.empty       = empty_s;
    assign bus.full        = full_s;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    // Driven only from registered state: no path from InPort_out.
    assign bus.InPort_Data = empty_s ? hold_q : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_in_port_fifo.sv
// -----------------------------------------------------------------------------
// tb_in_port_fifo
// Purpose : Directed self-checking bench for in_port_fifo with hand-computed
//           expected values.
// -----------------------------------------------------------------------------
module tb_in_port_fifo;

    logic clk;
    logic clr;
    int   n_vec;
    int   n_miss;

    in_port_fifo_if #(.DATA_WIDTH(32), .ADDR_W(2)) bus ();

    in_port_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .ADDR_W     (2)
    ) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.ext_valid = 1'b1;
        bus.ext_data  = w;
        tick();
        bus.ext_valid = 1'b0;
    endtask

    // Hold the strobe high for n cycles, then drop it; the pop lands on the
    // edge that sees the drop.
    task automatic strobe(input int n);
        bus.InPort_out = 1'b1;
        repeat (n) tick();
        bus.InPort_out = 1'b0;
        tick();
    endtask

    logic [31:0] exp_w [4];

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        clr            = 1'b1;
        bus.ext_data   = 32'h0;
        bus.ext_valid  = 1'b0;
        bus.InPort_out = 1'b0;
        bus.flag_clr   = 1'b0;
        tick();
        tick();
        clr = 1'b0;

        // Reset state
        check_vec("rst_empty", {31'd0, bus.empty}, 32'd1);
        check_vec("rst_full",  {31'd0, bus.full}, 32'd0);
        check_vec("rst_count", {29'd0, bus.count}, 32'd0);
        check_vec("rst_ready", {31'd0, bus.ext_ready}, 32'd1);
        check_vec("rst_data",  bus.InPort_Data, 32'd0);
        check_vec("rst_ovf",   {31'd0, bus.overflow}, 32'd0);
        check_vec("rst_udf",   {31'd0, bus.underflow}, 32'd0);

        // Single push, visible the edge after the push
        push_word(32'hFCAE1020);
        check_vec("p1_data",  bus.InPort_Data, 32'hFCAE1020);
        check_vec("p1_count", {29'd0, bus.count}, 32'd1);
        check_vec("p1_empty", {31'd0, bus.empty}, 32'd0);
        check_vec("p1_ready", {31'd0, bus.ext_ready}, 32'd1);

        // Two-cycle strobe consumes exactly one word, data stable meanwhile
        bus.InPort_out = 1'b1;
        tick();
        check_vec("s1_data_a",  bus.InPort_Data, 32'hFCAE1020);
        tick();
        check_vec("s1_data_b",  bus.InPort_Data, 32'hFCAE1020);
        check_vec("s1_count_b", {29'd0, bus.count}, 32'd1);
        bus.InPort_out = 1'b0;
        tick();
        check_vec("s1_count", {29'd0, bus.count}, 32'd0);
        check_vec("s1_empty", {31'd0, bus.empty}, 32'd1);
        check_vec("s1_hold",  bus.InPort_Data, 32'hFCAE1020);

        // Fill to full, then an overflowing fifth word
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
        for (int i = 0; i < 4; i++) push_word(exp_w[i]);
        check_vec("f_full",  {31'd0, bus.full}, 32'd1);
        check_vec("f_ready", {31'd0, bus.ext_ready}, 32'd0);
        check_vec("f_count", {29'd0, bus.count}, 32'd4);
        push_word(32'h55);
        check_vec("ovf_set",   {31'd0, bus.overflow}, 32'd1);
        check_vec("ovf_count", {29'd0, bus.count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_vec("f_order", bus.InPort_Data, exp_w[i]);
            strobe(1);
        end
        check_vec("f_drain_count", {29'd0, bus.count}, 32'd0);
        check_vec("f_drain_hold",  bus.InPort_Data, 32'h44);
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        check_vec("ovf_clr", {31'd0, bus.overflow}, 32'd0);

        // Pointer wrap: 3 in / 3 out, then 4 in / 4 out
        for (int i = 0; i < 3; i++) push_word(32'h101 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            check_vec("w3_order", bus.InPort_Data, 32'h101 + 32'(i));
            strobe(1);
        end
        for (int i = 0; i < 4; i++) push_word(32'h201 + 32'(i));
        check_vec("w4_count", {29'd0, bus.count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_vec("w4_order", bus.InPort_Data, 32'h201 + 32'(i));
            strobe(1);
        end
        check_vec("w_count", {29'd0, bus.count}, 32'd0);

        // Pop and push on the same edge with count=1
        push_word(32'hA);
        bus.InPort_out = 1'b1;
        tick();
        bus.InPort_out = 1'b0;
        bus.ext_valid  = 1'b1;
        bus.ext_data   = 32'hB;
        tick();
        bus.ext_valid  = 1'b0;
        check_vec("pp_count", {29'd0, bus.count}, 32'd1);
        check_vec("pp_data",  bus.InPort_Data, 32'hB);
        check_vec("pp_udf",   {31'd0, bus.underflow}, 32'd0);
        strobe(1);
        check_vec("pp_drain", bus.InPort_Data, 32'hB);

        // Pop on empty coinciding with a push: underflow, word retained
        bus.InPort_out = 1'b1;
        tick();
        bus.InPort_out = 1'b0;
        bus.ext_valid  = 1'b1;
        bus.ext_data   = 32'hC;
        tick();
        bus.ext_valid  = 1'b0;
        check_vec("ep_udf",   {31'd0, bus.underflow}, 32'd1);
        check_vec("ep_count", {29'd0, bus.count}, 32'd1);
        check_vec("ep_data",  bus.InPort_Data, 32'hC);
        strobe(1);
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        check_vec("udf_clr", {31'd0, bus.underflow}, 32'd0);

        // Plain strobe on empty FIFO
        strobe(1);
        check_vec("e_udf",   {31'd0, bus.underflow}, 32'd1);
        check_vec("e_data",  bus.InPort_Data, 32'hC);
        check_vec("e_count", {29'd0, bus.count}, 32'd0);

        // Set beats clear on the same edge
        bus.InPort_out = 1'b1;
        tick();
        bus.InPort_out = 1'b0;
        bus.flag_clr   = 1'b1;
        tick();
        check_vec("setwin_udf", {31'd0, bus.underflow}, 32'd1);
        tick();
        bus.flag_clr = 1'b0;
        check_vec("clr2_udf", {31'd0, bus.underflow}, 32'd0);

        // Full FIFO: pop and dropped push on the same edge, with flag_clr
        for (int i = 0; i < 4; i++) push_word(32'h31 + 32'(i));
        check_vec("f2_full", {31'd0, bus.full}, 32'd1);
        bus.InPort_out = 1'b1;
        tick();
        bus.InPort_out = 1'b0;
        bus.ext_valid  = 1'b1;
        bus.ext_data   = 32'h35;
        bus.flag_clr   = 1'b1;
        tick();
        bus.ext_valid  = 1'b0;
        bus.flag_clr   = 1'b0;
        check_vec("fp_ovf",   {31'd0, bus.overflow}, 32'd1);
        check_vec("fp_count", {29'd0, bus.count}, 32'd3);
        check_vec("fp_data",  bus.InPort_Data, 32'h32);
        check_vec("fp_ready", {31'd0, bus.ext_ready}, 32'd1);

        // Reset with two words buffered and the strobe held across it
        strobe(1);
        check_vec("pre_rst_count", {29'd0, bus.count}, 32'd2);
        bus.InPort_out = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_vec("mr_count", {29'd0, bus.count}, 32'd0);
        check_vec("mr_data",  bus.InPort_Data, 32'd0);
        check_vec("mr_empty", {31'd0, bus.empty}, 32'd1);
        check_vec("mr_ovf",   {31'd0, bus.overflow}, 32'd0);
        tick();
        check_vec("mr_udf_a", {31'd0, bus.underflow}, 32'd0);
        bus.InPort_out = 1'b0;
        tick();
        check_vec("mr_udf_b",  {31'd0, bus.underflow}, 32'd1);
        check_vec("mr_data_b", bus.InPort_Data, 32'd0);
        check_vec("mr_count_b", {29'd0, bus.count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/in_port_fifo.md
Name: in_port_fifo

Overview:
- Input-port counterpart to the OutPort register.
- Buffers words pushed by an external device through a valid/ready handshake in a small FIFO.
- Presents the head word on InPort_Data, which the datapath gates onto the bus when InPort_out is asserted for the "in" instruction.
- Consumes exactly one word per InPort_out assertion, regardless of how many cycles the assertion lasts.

Parameters:
- DATA_WIDTH, 32, width of each buffered word and of InPort_Data.
- DEPTH, 4, number of FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous active-high reset.
- ext_data  input  DATA_WIDTH  word offered by the external device.
- ext_valid  input  1  external device has a word on ext_data.
- ext_ready  output  1  FIFO can accept a word; equals !full.
- InPort_out  input  1  CPU bus-drive strobe for the input port; may be held several cycles.
- InPort_Data  output  DATA_WIDTH  value the datapath drives onto the bus.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds DEPTH words.
- count  output  ADDR_W+1  number of words held, 0..DEPTH.
- overflow  output  1  sticky; ext_valid was seen while full.
- underflow  output  1  sticky; a CPU read completed while empty.
- flag_clr  input  1  clears overflow and underflow.

Behaviour:
- Reset (clr=1 at a clock edge):
  - Pointers, count and the hold register go to 0; empty=1, full=0.
  - overflow=0, underflow=0, InPort_Data=0, internal strobe_prev=0.
  - Reset overrides every other input in the same cycle.
- Push:
  - Occurs on a clock edge where ext_valid=1 and ext_ready=1.
  - ext_data is written at the write pointer; the write pointer increments modulo DEPTH.
- ext_ready is combinational from registered state: !full. It never depends on ext_valid or InPort_out in the same cycle.
- Pop detection:
  - strobe_prev registers InPort_out every cycle.
  - A read completes on an edge where strobe_prev=1 and InPort_out=0, i.e. the falling edge of the strobe.
  - Result: InPort_Data is stable for the whole assertion window, and a 2-cycle strobe consumes exactly one word.
- Pop when non-empty:
  - The head word is copied into the hold register; the read pointer increments modulo DEPTH.
- Pop when empty:
  - Pointers, count and hold are unchanged; underflow sets.
- InPort_Data:
  - Equals the head entry when empty=0.
  - Equals the hold register (last consumed word, 0 after reset) when empty=1.
- Latency: a word pushed into an empty FIFO appears on InPort_Data at the edge following the push.
- Simultaneous push and pop in the same edge (not full):
  - Both take effect and count is unchanged.
  - When count was 0, no pop occurs: an empty pop sets underflow, and the pushed word is retained.
- When full:
  - ext_ready=0 and ext_valid is ignored for data.
  - If ext_valid=1, overflow sets and the word is dropped.
  - A pop in the same cycle frees a slot only from the next cycle on.
- Wrap-around:
  - Pointers wrap from DEPTH-1 to 0.
  - count is tracked separately so full and empty are never ambiguous.
- Flag clear:
  - flag_clr=1 clears both sticky flags.
  - If a set condition coincides with flag_clr, the set wins.
- Reset mid-operation:
  - Buffered words are discarded.
  - If InPort_out is still high across the reset, the falling edge after reset completes a read (against an empty FIFO: underflow sets).
- No combinational path from InPort_out to InPort_Data.

Test Plan:
- Reset, then push 0xFCAE1020 (one cycle valid) -> next cycle InPort_Data=0xFCAE1020, count=1, empty=0, ext_ready=1.
- Hold InPort_out high for 2 cycles, then low -> InPort_Data stays 0xFCAE1020 during the strobe; after the falling-edge clock, count=0, empty=1, InPort_Data=0xFCAE1020 (hold).
- Push 0x11, 0x22, 0x33, 0x44 back-to-back -> full=1, ext_ready=0, count=4. A fifth valid word 0x55 -> dropped, overflow=1. Four strobes read 0x11, 0x22, 0x33, 0x44 in order.
- Steps:
  - Fill 3 entries, perform 3 reads.
  - Then fill 4 entries (pointer wrap) and read all 4.
  - -> Order is preserved, count returns to 0.
- With count=1 (head 0xA), the strobe falls in the same cycle as a push of 0xB -> count stays 1, InPort_Data=0xB next cycle, hold=0xA.
- Steps:
  - Strobe on empty FIFO -> underflow=1, InPort_Data unchanged.
  - flag_clr -> flags 0.
  - Assert clr with 2 words buffered -> count=0, InPort_Data=0.
